// File: rtl/mdu.sv
// mdu -- multiply/divide unit for the E stage of the five-stage MIPS pipeline.
//
// Executes mult/multu/div/divu with a fixed multi-cycle latency, services
// mthi/mtlo in a single edge, and holds the architectural HI/LO registers.
// The 64-bit product and the quotient/remainder are computed combinationally
// from the operands present at the start edge. They are parked in shadow
// registers and committed to HI/LO on the edge where busy falls.
//
// Configuration macro: MDU_DIV_EN
//   defined   -> div/divu implemented
//   undefined -> no divider is built; op 3/4 act as no-ops
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset, clears all state
//   start  in   E-stage instruction is an MDU op
//   op     in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A, B   in   rs / rt operands (32 bits)
//   busy   out  multi-cycle operation in flight
//   HI, LO out  architectural HI / LO registers
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [0:0]  state_r;
  logic [3:0]  cnt_r;
  logic [31:0] hi_n_r;
  logic [31:0] lo_n_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic [63:0] prod_signed_s;
  logic [63:0] prod_unsigned_s;
  logic [3:0]  cnt_load_s;

  // Full 64-bit products; sign-extending to 64 bits keeps the signed multiply exact.
  assign prod_signed_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_unsigned_s = {32'd0, A} * {32'd0, B};

  // Latency loaded into the down-counter for the op being started.
  assign cnt_load_s = ((op == OP_DIV) || (op == OP_DIVU)) ? DIV_CNT : MULT_CNT;

`ifdef MDU_DIV_EN
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Quotient/remainder with the two architecturally defined corner cases handled
  // explicitly, since the language leaves them undefined or overflowing.
  always_comb begin
    quot_s = 32'hFFFF_FFFF;
    rem_s  = A;
    if (B == 32'd0) begin
      quot_s = 32'hFFFF_FFFF;
      rem_s  = A;
    end else if (op == OP_DIV) begin
      if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = $signed(A) / $signed(B);
        rem_s  = $signed(A) % $signed(B);
      end
    end else begin
      quot_s = A / B;
      rem_s  = A % B;
    end
  end
`endif

  // Control FSM, latency counter, shadow result registers and HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      hi_n_r  <= 32'd0;
      lo_n_r  <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                hi_n_r  <= prod_signed_s[63:32];
                lo_n_r  <= prod_signed_s[31:0];
                cnt_r   <= cnt_load_s;
                state_r <= ST_BUSY;
              end
              OP_MULTU: begin
                hi_n_r  <= prod_unsigned_s[63:32];
                lo_n_r  <= prod_unsigned_s[31:0];
                cnt_r   <= cnt_load_s;
                state_r <= ST_BUSY;
              end
`ifdef MDU_DIV_EN
              OP_DIV, OP_DIVU: begin
                hi_n_r  <= rem_s;
                lo_n_r  <= quot_s;
                cnt_r   <= cnt_load_s;
                state_r <= ST_BUSY;
              end
`endif
              OP_MTHI: hi_r <= A;
              OP_MTLO: lo_r <= A;
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // start is ignored here; the hazard unit keeps MDU ops out while busy.
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            hi_r    <= hi_n_r;
            lo_r    <= lo_n_r;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign busy = (state_r == ST_BUSY);
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- directed self-checking bench for mdu.
// Covers reset, signed/unsigned multiply, back-to-back issue, operand capture,
// mthi/mtlo, ignored ops, reset in mid-operation and, depending on MDU_DIV_EN,
// either the divider results or div/divu behaving as no-ops.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op for one start edge, then drop start.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
  endtask

  // Count busy cycles (bounded), checking HI/LO hold and scrambling operands.
  task automatic wait_idle(output int cyc, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    cyc = 0;
    while ((busy === 1'b1) && (cyc < 20)) begin
      cyc++;
      check("hold_hi", HI, hold_hi);
      check("hold_lo", LO, hold_lo);
      A = ~A;
      B = B + 32'd1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // mult -2 * 3
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy", {31'd0, busy}, 32'd1);
    wait_idle(n, 32'd0, 32'd0);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // multu same operands, issued the first cycle busy is low
    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    check("multu_busy", {31'd0, busy}, 32'd1);
    wait_idle(n, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", HI, 32'd2);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    // signed extreme: (-2^31)^2 = 2^62
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    wait_idle(n, 32'd2, 32'hFFFF_FFFA);
    check("mult_min_hi", HI, 32'h4000_0000);
    check("mult_min_lo", LO, 32'd0);

    // unsigned extreme
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n, 32'h4000_0000, 32'd0);
    check("multu_max_hi", HI, 32'hFFFF_FFFE);
    check("multu_max_lo", LO, 32'd1);

    // -5 * -7 = 35
    issue(3'd1, 32'hFFFF_FFFB, 32'hFFFF_FFF9);
    wait_idle(n, 32'hFFFF_FFFE, 32'd1);
    check("mult_neg_hi", HI, 32'd0);
    check("mult_neg_lo", LO, 32'd35);

    // mthi then mtlo on consecutive edges
    issue(3'd5, 32'h1234_5678, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_lo", LO, 32'd35);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_hi", HI, 32'h1234_5678);
    check("mtlo_lo", LO, 32'h9ABC_DEF0);

    // op 0 and op 7 have no effect
    issue(3'd0, 32'h5555_5555, 32'd7);
    issue(3'd7, 32'hAAAA_AAAA, 32'd7);
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", HI, 32'h1234_5678);
    check("nop_lo", LO, 32'h9ABC_DEF0);

`ifdef MDU_DIV_EN
    // div -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_busy", {31'd0, busy}, 32'd1);
    wait_idle(n, 32'h1234_5678, 32'h9ABC_DEF0);
    check("div_cycles", n, 32'd10);
    check("div_hi", HI, 32'hFFFF_FFFF);
    check("div_lo", LO, 32'hFFFF_FFFD);
    // divu by zero
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    check("divz_hi", HI, 32'd7);
    check("divz_lo", LO, 32'hFFFF_FFFF);
    // signed overflow
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n, 32'd7, 32'hFFFF_FFFF);
    check("divov_hi", HI, 32'd0);
    check("divov_lo", LO, 32'h8000_0000);
`else
    // divider absent: div/divu are no-ops
    issue(3'd3, 32'd10, 32'd3);
    check("div_off_busy", {31'd0, busy}, 32'd0);
    issue(3'd4, 32'd10, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    check("divu_off_busy", {31'd0, busy}, 32'd0);
    check("div_off_hi", HI, 32'h1234_5678);
    check("div_off_lo", LO, 32'h9ABC_DEF0);
`endif

    // mult 10 * 3
    issue(3'd1, 32'd10, 32'd3);
    wait_idle(n, HI, LO);
    check("mult10_cycles", n, 32'd5);
    check("mult10_hi", HI, 32'd0);
    check("mult10_lo", LO, 32'd30);

    // reset at busy cycle 4 discards the in-flight result
`ifdef MDU_DIV_EN
    issue(3'd3, 32'd100, 32'd7);
`else
    issue(3'd1, 32'd7, 32'd9);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", HI, 32'd0);
    check("mid_rst_lo", LO, 32'd0);
    #2;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
